imem_loader: RTL and testbench

- Boot-time program loader upstream of `top`.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words into the instruction memory write port.
- Holds the core in reset until a complete, checksum-verified image has been written. This replaces simulation-only memory preloading with a synthesizable load path.

---
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader. Receives a byte stream over a valid/ready
//   handshake, assembles little-endian 32-bit instruction words, writes them
//   through the instruction memory write port, and holds the core in reset
//   until a complete, checksum-verified image has been written.
//
//   Stream layout: LEN_LO, LEN_HI (16-bit word count N), N*4 data bytes,
//   then one checksum byte equal to the XOR of every preceding byte.
//
// Ports
//   clk        : system clock
//   n_rst      : asynchronous active-low reset
//   start      : one-cycle pulse that begins a new load (ignored while busy)
//   byte_valid : byte_data holds a valid byte
//   byte_data  : stream byte
//   byte_ready : loader can accept a byte this cycle (decoded from state)
//   imem_we    : instruction memory write enable, one-cycle pulse
//   imem_waddr : word address of the write
//   imem_wdata : instruction word to write
//   core_n_rst : active-low core reset, high only once the image is verified
//   busy       : load in progress
//   done       : image loaded and verified, core running
//   err        : load failed (length or checksum)

module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_n_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    RUN,
    ERROR
  } state_t;

  state_t state;
  state_t next_state;

  logic [7:0]        len_lo;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift;
  logic [7:0]        csum;

  logic        accept;
  logic [15:0] len_word;
  logic        len_too_big;
  logic        len_zero;
  logic        word_end;
  logic        last_word;
  logic        enter_load;

  assign byte_ready  = (state == LEN_LO) || (state == LEN_HI) ||
                       (state == DATA)   || (state == CSUM);
  assign accept      = byte_valid && byte_ready;
  assign len_word    = {byte_data, len_lo};
  assign len_too_big = ({16'd0, len_word} > MAX_WORDS);
  assign len_zero    = (len_word == 16'd0);
  assign word_end    = (byte_cnt == 2'd3);
  assign last_word   = (word_idx == last_idx);
  // A load starts from any resting state; start is ignored while busy.
  assign enter_load  = (next_state == LEN_LO) && (state != LEN_LO);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode. Transitions out of the byte-consuming states only
  // happen on an accepted byte, so a stalled stream simply holds state.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, RUN, ERROR: begin
        if (start) next_state = LEN_LO;
      end
      LEN_LO: begin
        if (accept) next_state = LEN_HI;
      end
      LEN_HI: begin
        if (accept) begin
          if (len_too_big)   next_state = ERROR;
          else if (len_zero) next_state = CSUM;
          else               next_state = DATA;
        end
      end
      DATA: begin
        if (accept && word_end && last_word) next_state = CSUM;
      end
      CSUM: begin
        if (accept) next_state = (byte_data == csum) ? RUN : ERROR;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs. Status outputs are computed from
  // next_state so they line up exactly with the state they describe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      len_lo     <= '0;
      last_idx   <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      core_n_rst <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      busy       <= (next_state == LEN_LO) || (next_state == LEN_HI) ||
                    (next_state == DATA)   || (next_state == CSUM);
      done       <= (next_state == RUN);
      core_n_rst <= (next_state == RUN);
      err        <= (next_state == ERROR);

      if (enter_load) begin
        word_idx <= '0;
        byte_cnt <= '0;
        shift    <= '0;
        csum     <= '0;
      end else if (accept) begin
        case (state)
          LEN_LO: begin
            len_lo <= byte_data;
            csum   <= csum ^ byte_data;
          end
          LEN_HI: begin
            // Only meaningful when the length is in range; N-1 fits ADDR_W.
            last_idx <= ADDR_W'(len_word - 16'd1);
            csum     <= csum ^ byte_data;
          end
          DATA: begin
            // Bytes enter at the top so the first byte ends up lowest.
            csum     <= csum ^ byte_data;
            shift    <= {byte_data, shift[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (word_end) begin
              imem_we    <= 1'b1;
              imem_waddr <= word_idx;
              imem_wdata <= {byte_data, shift};
              word_idx   <= word_idx + ADDR_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed bench for imem_loader. A stream-level model turns each byte
//   stream into the list of memory writes and the final load status; a
//   compare process checks every write and the output invariants each cycle.

module tb_imem_loader;

  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 1 << ADDR_W;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk;
  logic              n_rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_n_rst;
  logic              busy;
  logic              done;
  logic              err;

  int  vectors     = 0;
  int  miscompares = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];

  logic [7:0] good_s[$];
  logic [7:0] bad_s[$];
  logic [7:0] zero_s[$];
  logic [7:0] over_s[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_n_rst (core_n_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Expected writes: every complete word in the bytes actually sent.
  task automatic modelLoad(input logic [7:0] s[$], input int n_sent);
    int n;
    if (n_sent < 2) return;
    n = int'({s[1], s[0]});
    if (n > MAX_WORDS) return;
    for (int w = 0; w < n; w++) begin
      if (2 + 4 * w + 4 <= n_sent) begin
        wr_t e;
        e.addr = ADDR_W'(w);
        e.data = {s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]};
        exp_q.push_back(e);
      end
    end
  endtask

  // Expected load status after n_sent bytes of stream s.
  task automatic modelStatus(input logic [7:0] s[$], input int n_sent,
                             output logic e_done, output logic e_err,
                             output logic e_busy);
    int n;
    int need;
    logic [7:0] x;
    e_done = 1'b0;
    e_err  = 1'b0;
    e_busy = 1'b1;
    if (n_sent < 2) return;
    n = int'({s[1], s[0]});
    if (n > MAX_WORDS) begin
      e_err  = 1'b1;
      e_busy = 1'b0;
      return;
    end
    need = 2 + 4 * n + 1;
    if (n_sent < need) return;
    x = 8'h00;
    for (int i = 0; i < need - 1; i++) x = x ^ s[i];
    e_busy = 1'b0;
    if (x == s[need-1]) e_done = 1'b1;
    else                e_err  = 1'b1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte and wait (bounded) until the loader takes it.
  task automatic sendByte(input logic [7:0] b);
    logic ok;
    logic r;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      r = byte_ready;
      @(posedge clk); #1;
      ok = r;
    end
    byte_valid = 1'b0;
    checkOutput("byte_accept", 32'(ok), 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] s[$], input int n_send,
                               input bit throttle, input bit mid_start);
    obs_q.delete();
    modelLoad(s, n_send);
    pulseStart();
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("done_after_start", 32'(done), 32'd0);
    checkOutput("err_after_start", 32'(err), 32'd0);
    checkOutput("core_rst_after_start", 32'(core_n_rst), 32'd0);
    for (int i = 0; i < n_send; i++) begin
      if (throttle) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
        if (mid_start && i == 8) begin
          pulseStart();
          checkOutput("busy_mid_start", 32'(busy), 32'd1);
        end
      end
      sendByte(s[i]);
    end
  endtask

  task automatic checkFinal(input string tag, input logic [7:0] s[$], input int n_sent);
    logic e_done;
    logic e_err;
    logic e_busy;
    modelStatus(s, n_sent, e_done, e_err, e_busy);
    @(negedge clk);
    checkOutput({tag, "_done"}, 32'(done), 32'(e_done));
    checkOutput({tag, "_err"}, 32'(err), 32'(e_err));
    checkOutput({tag, "_core_n_rst"}, 32'(core_n_rst), 32'(e_done));
    checkOutput({tag, "_busy"}, 32'(busy), 32'(e_busy));
    checkOutput({tag, "_byte_ready"}, 32'(byte_ready), 32'(e_busy));
    checkOutput({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Hand-computed words of the reference program.
  task automatic checkGoodWrites(input string tag);
    checkOutput({tag, "_wr_count"}, 32'(obs_q.size()), 32'd3);
    checkOutput({tag, "_wr0_addr"}, 32'(obs_q[0].addr), 32'd0);
    checkOutput({tag, "_wr0_data"}, obs_q[0].data, 32'h00A00093);
    checkOutput({tag, "_wr1_addr"}, 32'(obs_q[1].addr), 32'd1);
    checkOutput({tag, "_wr1_data"}, obs_q[1].data, 32'h00500113);
    checkOutput({tag, "_wr2_addr"}, 32'(obs_q[2].addr), 32'd2);
    checkOutput({tag, "_wr2_data"}, obs_q[2].data, 32'h002081B3);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    checkOutput({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    checkOutput({tag, "_imem_waddr"}, 32'(imem_waddr), 32'd0);
    checkOutput({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    checkOutput({tag, "_core_n_rst"}, 32'(core_n_rst), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    good_s = '{8'h03, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h13, 8'h01,
               8'h50, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00, 8'h60};
    bad_s  = good_s;
    bad_s[14] = 8'h61;
    zero_s = '{8'h00, 8'h00, 8'h00};
    over_s = '{8'h01, 8'h01};

    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    n_rst      = 1'b1;
    #1 n_rst = 1'b0;
    #2;
    checkResetValues("reset");

    // Compare process: every memory write against the model, plus
    // output relationships that must hold in every state.
    fork
      forever begin
        @(negedge clk);
        if (n_rst) begin
          checkOutput("busy_vs_ready", 32'(busy), 32'(byte_ready));
          checkOutput("done_vs_core_rst", 32'(done), 32'(core_n_rst));
          checkOutput("done_and_err", 32'(done & err), 32'd0);
          if (imem_we) begin
            wr_t got;
            got.addr = imem_waddr;
            got.data = imem_wdata;
            obs_q.push_back(got);
            if (exp_q.size() == 0) begin
              checkOutput("unexpected_write", 32'(imem_we), 32'd0);
            end else begin
              wr_t e;
              e = exp_q.pop_front();
              checkOutput("waddr", 32'(imem_waddr), 32'(e.addr));
              checkOutput("wdata", imem_wdata, e.data);
            end
          end
        end
      end
    join_none

    #19 n_rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_ready", 32'(byte_ready), 32'd0);

    $display("[TB] good 3-word load");
    applyStimulus(good_s, 15, 1'b0, 1'b0);
    checkFinal("good", good_s, 15);
    checkGoodWrites("good");

    $display("[TB] bad checksum then recovery");
    applyStimulus(bad_s, 15, 1'b0, 1'b0);
    checkFinal("badcs", bad_s, 15);
    checkOutput("badcs_wr_count", 32'(obs_q.size()), 32'd3);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("badcs_hold_err", 32'(err), 32'd1);
    applyStimulus(good_s, 15, 1'b0, 1'b0);
    checkFinal("recover", good_s, 15);
    checkGoodWrites("recover");

    $display("[TB] zero length");
    applyStimulus(zero_s, 3, 1'b0, 1'b0);
    checkFinal("zero", zero_s, 3);
    checkOutput("zero_wr_count", 32'(obs_q.size()), 32'd0);

    $display("[TB] oversize length");
    applyStimulus(over_s, 2, 1'b0, 1'b0);
    checkFinal("over", over_s, 2);
    checkOutput("over_wr_count", 32'(obs_q.size()), 32'd0);

    $display("[TB] throttled stream with start mid-data");
    applyStimulus(good_s, 15, 1'b1, 1'b1);
    checkFinal("throttle", good_s, 15);
    checkGoodWrites("throttle");

    $display("[TB] reset mid-load");
    applyStimulus(good_s, 6, 1'b0, 1'b0);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    checkResetValues("midreset");
    checkOutput("midreset_writes_left", 32'(exp_q.size()), 32'd0);
    checkOutput("midreset_wr_count", 32'(obs_q.size()), 32'd1);
    #10 n_rst = 1'b1;
    @(posedge clk); #1;
    applyStimulus(good_s, 15, 1'b0, 1'b0);
    checkFinal("afterreset", good_s, 15);
    checkGoodWrites("afterreset");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
